// File: rtl/fetch_unit_pkg.sv
// Shared defaults, the prefetch FIFO entry layout and the PC alignment helper
// used by the fetch front-end.
package fetch_unit_pkg;

   localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
   localparam int          FIFO_DEPTH_DEF   = 2;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] word;
   } fetch_entry_t;

   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, word} pairs. Flush wins over push and pop.
module fetch_fifo
   import fetch_unit_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH_DEF
)(
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_flush,
   input  logic                         i_push,
   input  logic [63:0]                  i_din,
   input  logic                         i_pop,
   output logic [$clog2(DEPTH+1)-1:0]   o_count,
   output logic [63:0]                  o_head
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [63:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_q;
   logic [AW-1:0] rd_q;
   logic [CW-1:0] cnt_q;

   // Pointers wrap naturally because DEPTH is a power of two (2 or 4).
   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_flush) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (i_push) wr_q <= wr_q + AW'(1);
         if (i_pop)  rd_q <= rd_q + AW'(1);
         cnt_q <= cnt_q + CW'(i_push) - CW'(i_pop);
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (i_push && !i_flush) begin
         mem_q[wr_q] <= i_din;
      end
   end

   assign o_count = cnt_q;
   assign o_head  = mem_q[rd_q];

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch front-end: single-outstanding memory request, prefetch FIFO to the
// decoder, redirect flush with discard of a stale in-flight fetch.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
   parameter int          FIFO_DEPTH   = FIFO_DEPTH_DEF
)(
   input  logic        i_clk,
   input  logic        i_rst_n,
   output logic [31:0] o_mem_addr,
   output logic        o_mem_req,
   input  logic        i_mem_ack,
   input  logic [31:0] i_mem_data,
   output logic [31:0] o_opcode,
   output logic [31:0] o_pc,
   output logic        o_valid,
   input  logic        i_ready,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic        o_misaligned
);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DISCARD = 2'd2} state_t;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   state_t        state_q;
   logic [31:0]   fetch_pc_q;
   logic [31:0]   pend_pc_q;
   logic          misaligned_q;
   logic [CW-1:0] count;
   logic          push;
   logic          pop;
   logic          room;
   logic [31:0]   redir_pc;
   fetch_entry_t  push_e;
   fetch_entry_t  head_e;

   assign redir_pc = align_pc(i_redirect_pc);
   assign o_valid  = (count != '0);
   // A redirect flushes the FIFO, so it also cancels any pop or push this cycle.
   assign pop      = o_valid && i_ready && !i_redirect;
   assign push     = (state_q == REQ) && i_mem_ack && !i_redirect;
   assign room     = (int'(count) + int'(push) - int'(pop)) < FIFO_DEPTH;
   assign push_e   = '{pc: fetch_pc_q, word: i_mem_data};

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q      <= IDLE;
         fetch_pc_q   <= RESET_VECTOR;
         pend_pc_q    <= RESET_VECTOR;
         misaligned_q <= 1'b0;
      end else begin
         misaligned_q <= i_redirect && (i_redirect_pc[1:0] != 2'b00);
         case (state_q)
            IDLE: begin
               if (i_redirect) begin
                  fetch_pc_q <= redir_pc;
                  state_q    <= REQ;
               end else if (room) begin
                  state_q <= REQ;
               end
            end
            REQ: begin
               if (i_mem_ack && i_redirect) begin
                  fetch_pc_q <= redir_pc;
               end else if (i_mem_ack) begin
                  fetch_pc_q <= fetch_pc_q + 32'd4;
                  state_q    <= room ? REQ : IDLE;
               end else if (i_redirect) begin
                  pend_pc_q <= redir_pc;
                  state_q   <= DISCARD;
               end
            end
            DISCARD: begin
               // The bus keeps the stale address until its ack; only then restart.
               if (i_mem_ack) begin
                  fetch_pc_q <= i_redirect ? redir_pc : pend_pc_q;
                  state_q    <= i_redirect ? IDLE : REQ;
               end else if (i_redirect) begin
                  pend_pc_q <= redir_pc;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_flush (i_redirect),
      .i_push  (push),
      .i_din   (push_e),
      .i_pop   (pop),
      .o_count (count),
      .o_head  (head_e)
   );

   assign o_mem_req    = (state_q != IDLE);
   assign o_mem_addr   = fetch_pc_q;
   assign o_opcode     = head_e.word;
   assign o_pc         = head_e.pc;
   assign o_misaligned = misaligned_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a request/stream model predicts accepted words
// into a queue; a negedge monitor compares the FIFO head stream against it.
module tb_fetch_unit;

   localparam logic [31:0] RV    = 32'h0000_0100;
   localparam int          DEPTH = 2;
   localparam int          NCYC  = 4000;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] word;
   } item_t;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic [31:0] o_mem_addr;
   logic        o_mem_req;
   logic        i_mem_ack;
   logic [31:0] i_mem_data;
   logic [31:0] o_opcode;
   logic [31:0] o_pc;
   logic        o_valid;
   logic        i_ready;
   logic        i_redirect;
   logic [31:0] i_redirect_pc;
   logic        o_misaligned;

   fetch_unit #(.RESET_VECTOR(RV), .FIFO_DEPTH(DEPTH)) dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .o_mem_addr    (o_mem_addr),
      .o_mem_req     (o_mem_req),
      .i_mem_ack     (i_mem_ack),
      .i_mem_data    (i_mem_data),
      .o_opcode      (o_opcode),
      .o_pc          (o_pc),
      .o_valid       (o_valid),
      .i_ready       (i_ready),
      .i_redirect    (i_redirect),
      .i_redirect_pc (i_redirect_pc),
      .o_misaligned  (o_misaligned)
   );

   always #5 i_clk = ~i_clk;

   item_t exp_q[$];
   int    nvec = 0;
   int    nerr = 0;
   bit    done = 1'b0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: head stream, valid flag, misaligned pulse and post-reset values.
   bit prev_rst = 1'b1;
   bit prev_mis = 1'b0;
   always @(negedge i_clk) begin
      if (!done) begin
         if (prev_rst) begin
            check1 ("rst_mem_req", o_mem_req, 1'b0);
            check32("rst_mem_addr", o_mem_addr, RV);
            check32("rst_opcode", o_opcode, 32'h0);
            check32("rst_pc", o_pc, 32'h0);
            check1 ("rst_misaligned", o_misaligned, 1'b0);
         end else begin
            check1("misaligned", o_misaligned, prev_mis);
         end
         check1("valid", o_valid, exp_q.size() != 0);
         if (o_valid && exp_q.size() != 0) begin
            check32("head_pc", o_pc, exp_q[0].pc);
            check32("head_opcode", o_opcode, exp_q[0].word);
            if (i_ready && !i_redirect && i_rst_n) void'(exp_q.pop_front());
         end
         if (i_redirect || !i_rst_n) exp_q.delete();
         prev_rst = !i_rst_n;
         prev_mis = i_rst_n && i_redirect && (i_redirect_pc[1:0] != 2'b00);
      end
   end

   // Stream model: where the next instruction comes from, and whether the fetch
   // currently on the bus was overtaken by a redirect.
   logic [31:0] exp_pc    = RV;
   logic [31:0] req_addr  = '0;
   bit          outst     = 1'b0;
   bit          stale     = 1'b0;
   bit          gap       = 1'b0;
   bit          pend      = 1'b0;
   bit          prev_rst_s = 1'b1;
   item_t       pend_item;
   bit          exp_req, do_rst, do_ack, do_redir;
   logic [31:0] rpc;

   initial begin
      i_rst_n       = 1'b0;
      i_mem_ack     = 1'b0;
      i_mem_data    = '0;
      i_ready       = 1'b0;
      i_redirect    = 1'b0;
      i_redirect_pc = '0;
      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(posedge i_clk);
         #1;
         // Word accepted last cycle is now in the FIFO.
         if (pend) begin
            nvec++;
            if (exp_q.size() >= DEPTH) begin
               nerr++;
               $display("FAIL overflow: occupancy %0d, depth %0d", exp_q.size() + 1, DEPTH);
            end
            exp_q.push_back(pend_item);
            pend = 1'b0;
         end

         // A fetch is on the bus whenever one is outstanding or there is room,
         // except the first cycle out of reset and the cycle after a redirect
         // that coincides with a stale fetch retiring.
         exp_req = outst || (exp_q.size() < DEPTH && !prev_rst_s && !gap);
         check1("mem_req", o_mem_req, exp_req);
         if (outst) begin
            check32("addr_hold", o_mem_addr, req_addr);
         end else if (o_mem_req) begin
            check32("req_addr", o_mem_addr, exp_pc);
            req_addr = o_mem_addr;
            outst    = 1'b1;
            stale    = 1'b0;
         end

         if (cyc < 2)       do_rst = 1'b1;
         else if (cyc < 60) do_rst = 1'b0;
         else               do_rst = ($urandom_range(0, 199) == 0);
         do_ack   = outst && !do_rst && (cyc < 60 || $urandom_range(0, 9) < 6);
         do_redir = !do_rst && cyc >= 60 && $urandom_range(0, 99) < 6;
         case ($urandom_range(0, 4))
            0:       rpc = 32'h0000_0200;
            1:       rpc = 32'h0000_0300;
            2:       rpc = 32'h0000_0206;
            3:       rpc = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            default: rpc = $urandom;
         endcase

         i_rst_n       = !do_rst;
         i_mem_ack     = do_ack;
         i_mem_data    = $urandom;
         i_redirect    = do_redir;
         i_redirect_pc = rpc;
         if (cyc < 40)      i_ready = 1'b1;
         else if (cyc < 60) i_ready = 1'b0;
         else               i_ready = ($urandom_range(0, 9) < 7);

         if (do_rst) begin
            outst  = 1'b0;
            stale  = 1'b0;
            gap    = 1'b0;
            pend   = 1'b0;
            exp_pc = RV;
         end else begin
            gap = 1'b0;
            if (outst && do_ack) begin
               if (!stale && !do_redir) begin
                  pend_item = '{req_addr, i_mem_data};
                  pend      = 1'b1;
                  exp_pc    = exp_pc + 32'd4;
               end
               gap   = stale && do_redir;
               outst = 1'b0;
            end
            if (do_redir) begin
               stale  = 1'b1;
               exp_pc = rpc & ~32'd3;
            end
         end
         prev_rst_s = do_rst;
      end
      @(negedge i_clk);
      done = 1'b1;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
